// File: rtl/aes_shift_rows_pipe.sv
// rtl/aes_shift_rows_pipe.sv - Elastic pipelined ShiftRows/InvShiftRows stage for NB = 4, 6 or 8 columns
module aes_shift_rows_pipe #(
    parameter int NB     = 4,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_inv,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [32*NB-1:0]  in_state,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_state,
    output logic [TAG_W-1:0]  out_tag,
    output logic [2:0]        occupancy
);

    localparam int W = 32 * NB;

    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
        $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("aes_shift_rows_pipe: STAGES must be 1..4");
    end

    logic [W-1:0] fwd_state;
    logic [W-1:0] inv_state;
    logic [W-1:0] perm_state;

    // Pure wiring: each output byte picks its source byte from the row offset table.
    for (genvar gc = 0; gc < NB; gc++) begin : g_col
        for (genvar gr = 0; gr < 4; gr++) begin : g_row
            localparam int OFF  = (gr == 0) ? 0 :
                                  (gr == 1) ? 1 :
                                  (gr == 2) ? ((NB == 8) ? 3 : 2) :
                                              ((NB == 8) ? 4 : 3);
            localparam int FSRC = (gc + OFF) % NB;
            localparam int ISRC = (gc - OFF + NB) % NB;
            assign fwd_state[8*(4*gc+gr) +: 8] = in_state[8*(4*FSRC+gr) +: 8];
            assign inv_state[8*(4*gc+gr) +: 8] = in_state[8*(4*ISRC+gr) +: 8];
        end
    end

    assign perm_state = in_inv ? inv_state : fwd_state;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic [2:0]        occ_d;
    logic [W-1:0]      state_q [STAGES];
    logic [TAG_W-1:0]  tag_q   [STAGES];

    // A stage may move when out_ready is high or any later stage is empty;
    // written without a chain to keep the combinational graph flat.
    always_comb begin
        adv = '0;
        for (int i = 0; i < STAGES; i++) begin
            adv[i] = out_ready;
            for (int j = i + 1; j < STAGES; j++) begin
                adv[i] = adv[i] | !valid_q[j];
            end
        end
    end

    assign in_ready = !flush && (!valid_q[0] || adv[0]);

    always_comb begin
        valid_d = valid_q;
        load    = '0;
        if (!valid_q[0] || adv[0]) begin
            valid_d[0] = in_valid;
            load[0]    = in_valid;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (!valid_q[i] || adv[i]) begin
                valid_d[i] = valid_q[i-1];
                load[i]    = valid_q[i-1];
            end
        end
        if (flush) begin
            valid_d = '0;
            load    = '0;
        end
    end

    always_comb begin
        occ_d = 3'd0;
        for (int i = 0; i < STAGES; i++) begin
            occ_d = occ_d + {2'b00, valid_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            occupancy <= 3'd0;
        end else begin
            valid_q   <= valid_d;
            occupancy <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load[0]) begin
            state_q[0] <= perm_state;
            tag_q[0]   <= in_tag;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (load[i]) begin
                state_q[i] <= state_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    // Data registers are unreset, so the presented beat is masked while empty.
    assign out_valid = valid_q[STAGES-1];
    assign out_state = out_valid ? state_q[STAGES-1] : '0;
    assign out_tag   = out_valid ? tag_q[STAGES-1]   : '0;

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// tb/tb_aes_shift_rows_pipe.sv - Randomized self-checking bench for aes_shift_rows_pipe
module tb_aes_shift_rows_pipe;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_inv;
    logic         out_ready;
    logic [3:0]   in_tag;
    logic [255:0] in_state;
    int           sel;

    logic         ir0, ir1, ir2, ov0, ov1, ov2;
    logic [127:0] os0;
    logic [191:0] os1;
    logic [255:0] os2;
    logic [3:0]   ot0, ot1, ot2;
    logic [2:0]   oc0, oc1, oc2;

    logic         in_ready_m, out_valid_m;
    logic [255:0] out_state_m;
    logic [3:0]   out_tag_m;
    logic [2:0]   occ_m;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [255:0] st;
        logic [3:0]   tg;
    } beat_t;

    always #5 clk = ~clk;

    aes_shift_rows_pipe #(.NB(4), .STAGES(3), .TAG_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid && (sel == 0)), .in_ready(ir0), .in_inv(in_inv),
        .in_tag(in_tag), .in_state(in_state[127:0]),
        .out_valid(ov0), .out_ready(out_ready), .out_state(os0), .out_tag(ot0),
        .occupancy(oc0));

    aes_shift_rows_pipe #(.NB(6), .STAGES(2), .TAG_W(4)) dut6 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid && (sel == 1)), .in_ready(ir1), .in_inv(in_inv),
        .in_tag(in_tag), .in_state(in_state[191:0]),
        .out_valid(ov1), .out_ready(out_ready), .out_state(os1), .out_tag(ot1),
        .occupancy(oc1));

    aes_shift_rows_pipe #(.NB(8), .STAGES(1), .TAG_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid && (sel == 2)), .in_ready(ir2), .in_inv(in_inv),
        .in_tag(in_tag), .in_state(in_state),
        .out_valid(ov2), .out_ready(out_ready), .out_state(os2), .out_tag(ot2),
        .occupancy(oc2));

    always_comb begin
        in_ready_m  = ir0;
        out_valid_m = ov0;
        out_state_m = {128'b0, os0};
        out_tag_m   = ot0;
        occ_m       = oc0;
        case (sel)
            1: begin
                in_ready_m = ir1; out_valid_m = ov1; out_state_m = {64'b0, os1};
                out_tag_m = ot1; occ_m = oc1;
            end
            2: begin
                in_ready_m = ir2; out_valid_m = ov2; out_state_m = os2;
                out_tag_m = ot2; occ_m = oc2;
            end
            default: ;
        endcase
    end

    function automatic int nb_of(input int s);
        return (s == 0) ? 4 : (s == 1) ? 6 : 8;
    endfunction

    function automatic int stg_of(input int s);
        return (s == 0) ? 3 : (s == 1) ? 2 : 1;
    endfunction

    // Reference: state viewed as a 4 x nb byte matrix, each row rotated by its offset.
    function automatic logic [255:0] model(input logic [255:0] s, input int nb, input logic inv);
        logic [255:0] o;
        int offs[4];
        int src;
        o = '0;
        offs[0] = 0;
        offs[1] = 1;
        offs[2] = (nb == 8) ? 3 : 2;
        offs[3] = (nb == 8) ? 4 : 3;
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c + nb - offs[r]) % nb : (c + offs[r]) % nb;
                o[8*(4*c+r) +: 8] = s[8*(4*src+r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [255:0] rnd_state(input int nb);
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 4 * nb; k++) v[8*k +: 8] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_inv   = 1'b0;
        in_tag   = 4'h0;
        in_state = '0;
    endtask

    task automatic test_reset();
        sel = 0; rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        total++; if (out_valid_m !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid_m); end
        total++; if (occ_m !== 3'd0) begin bad++; $display("FAIL reset_occupancy got=%0d want=0", occ_m); end
        total++; if (out_state_m !== '0) begin bad++; $display("FAIL reset_out_state got=%h want=0", out_state_m); end
        total++; if (out_tag_m !== 4'h0) begin bad++; $display("FAIL reset_out_tag got=%h want=0", out_tag_m); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (in_ready_m !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready_m); end
    endtask

    task automatic test_fips();
        logic [255:0] vin, vout, st, exp_st;
        vin  = {128'b0, 128'h3052411ee55db4b8f198bfe0ae1127d4};
        vout = {128'b0, 128'he598271ef11141b8ae52b4e0305dbfd4};
        sel = 0; out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            st     = (t == 0) ? vin : vout;
            exp_st = (t == 0) ? vout : vin;
            @(negedge clk);
            in_valid = 1'b1; in_inv = (t == 1); in_tag = 4'(5 + t); in_state = st;
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                idle_inputs();
                #1;
                total++;
                if (out_valid_m !== (k == 3)) begin
                    bad++; $display("FAIL fips_latency t=%0d k=%0d got=%b want=%b", t, k, out_valid_m, (k == 3));
                end
            end
            total++;
            if (out_state_m !== exp_st) begin
                bad++; $display("FAIL fips_state t=%0d got=%h want=%h", t, out_state_m[127:0], exp_st[127:0]);
            end
            total++;
            if (out_tag_m !== 4'(5 + t)) begin
                bad++; $display("FAIL fips_tag t=%0d got=%h want=%h", t, out_tag_m, 4'(5 + t));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_nb8_index();
        logic [255:0] st;
        for (int k = 0; k < 32; k++) st[8*k +: 8] = 8'(k);
        sel = 2; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_inv = 1'b0; in_tag = 4'h9; in_state = st;
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (out_valid_m !== 1'b1) begin bad++; $display("FAIL nb8_valid got=%b want=1", out_valid_m); end
        total++; if (out_state_m[23:16] !== 8'h0e) begin bad++; $display("FAIL nb8_byte2 got=%h want=0e", out_state_m[23:16]); end
        total++; if (out_state_m[31:24] !== 8'h13) begin bad++; $display("FAIL nb8_byte3 got=%h want=13", out_state_m[31:24]); end
        total++;
        if (out_state_m !== model(st, 8, 1'b0)) begin
            bad++; $display("FAIL nb8_state got=%h want=%h", out_state_m, model(st, 8, 1'b0));
        end
        @(negedge clk);
    endtask

    task automatic test_random(input int s, input int n);
        beat_t q[$];
        beat_t b;
        int sent, cyc, nb;
        logic prev_stall;
        logic [255:0] prev_st;
        logic [3:0] prev_tg;
        sel = s; nb = nb_of(s); sent = 0; cyc = 0; prev_stall = 1'b0;
        prev_st = '0; prev_tg = '0;
        while ((sent < n || q.size() > 0) && cyc < 20 * n + 200) begin
            @(negedge clk);
            cyc++;
            in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
            in_inv    = 1'($urandom_range(0, 1));
            in_tag    = 4'($urandom_range(0, 15));
            in_state  = rnd_state(nb);
            out_ready = (sent >= n) || ($urandom_range(0, 2) != 0);
            #1;
            total++;
            if (int'(occ_m) !== q.size()) begin
                bad++; $display("FAIL rand_occupancy sel=%0d got=%0d want=%0d", s, occ_m, q.size());
            end
            if (prev_stall) begin
                total++;
                if (out_valid_m !== 1'b1 || out_state_m !== prev_st || out_tag_m !== prev_tg) begin
                    bad++; $display("FAIL rand_stall_hold sel=%0d got=%b/%h want=1/%h", s, out_valid_m, out_tag_m, prev_tg);
                end
            end
            if (out_valid_m && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rand_extra_beat sel=%0d got=%h want=none", s, out_tag_m);
                end else begin
                    b = q.pop_front();
                    if (out_state_m !== b.st || out_tag_m !== b.tg) begin
                        bad++; $display("FAIL rand_beat sel=%0d got=%h/%h want=%h/%h", s, out_tag_m, out_state_m, b.tg, b.st);
                    end
                end
            end
            if (in_valid && in_ready_m) begin
                b.st = model(in_state, nb, in_inv);
                b.tg = in_tag;
                q.push_back(b);
                sent++;
            end
            prev_stall = out_valid_m && !out_ready;
            prev_st = out_state_m;
            prev_tg = out_tag_m;
        end
        total++;
        if (sent != n || q.size() != 0) begin
            bad++; $display("FAIL rand_timeout sel=%0d got=%0d/%0d want=%0d/0", s, sent, q.size(), n);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back(input int s);
        beat_t q[$];
        beat_t b;
        int stg, nb;
        sel = s; stg = stg_of(s); nb = nb_of(s); out_ready = 1'b1;
        for (int i = 0; i < 20 + stg + 2; i++) begin
            @(negedge clk);
            in_valid = (i < 20);
            in_inv   = 1'(i % 2);
            in_tag   = 4'(i);
            in_state = rnd_state(nb);
            #1;
            total++;
            if (out_valid_m !== (i >= stg && i < 20 + stg)) begin
                bad++; $display("FAIL b2b_valid i=%0d got=%b want=%b", i, out_valid_m, (i >= stg && i < 20 + stg));
            end
            if (i < 20) begin
                total++;
                if (in_ready_m !== 1'b1) begin bad++; $display("FAIL b2b_in_ready i=%0d got=%b want=1", i, in_ready_m); end
            end
            if (out_valid_m && q.size() > 0) begin
                b = q.pop_front();
                total++;
                if (out_state_m !== b.st || out_tag_m !== b.tg) begin
                    bad++; $display("FAIL b2b_beat i=%0d got=%h want=%h", i, out_tag_m, b.tg);
                end
            end
            if (in_valid && in_ready_m) begin
                b.st = model(in_state, nb, in_inv);
                b.tg = in_tag;
                q.push_back(b);
            end
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        beat_t q[$];
        beat_t b;
        int max_occ, tagn;
        sel = 0; max_occ = 0; tagn = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            in_valid  = (i < 60);
            in_inv    = 1'($urandom_range(0, 1));
            in_tag    = 4'(tagn);
            in_state  = rnd_state(4);
            out_ready = (i >= 60) || (i % 3 == 0);
            #1;
            total++;
            if (int'(occ_m) !== q.size()) begin
                bad++; $display("FAIL bp_occupancy i=%0d got=%0d want=%0d", i, occ_m, q.size());
            end
            total++;
            if (in_ready_m !== !(q.size() == 3 && !out_ready)) begin
                bad++; $display("FAIL bp_in_ready i=%0d got=%b want=%b", i, in_ready_m, !(q.size() == 3 && !out_ready));
            end
            if (q.size() > max_occ) max_occ = q.size();
            if (out_valid_m && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL bp_extra got=%h want=none", out_tag_m);
                end else begin
                    b = q.pop_front();
                    if (out_tag_m !== b.tg || out_state_m !== b.st) begin
                        bad++; $display("FAIL bp_order i=%0d got=%h want=%h", i, out_tag_m, b.tg);
                    end
                end
            end
            if (in_valid && in_ready_m) begin
                b.st = model(in_state, 4, in_inv);
                b.tg = in_tag;
                q.push_back(b);
                tagn++;
            end
        end
        total++;
        if (max_occ != 3 || q.size() != 0) begin
            bad++; $display("FAIL bp_saturate got=%0d/%0d want=3/0", max_occ, q.size());
        end
        idle_inputs();
    endtask

    task automatic test_identity(input int s, input int pairs);
        logic [255:0] x, y;
        logic got;
        int nb;
        sel = s; nb = nb_of(s); out_ready = 1'b1;
        for (int p = 0; p < pairs; p++) begin
            x = rnd_state(nb);
            y = '0;
            for (int t = 0; t < 2; t++) begin
                @(negedge clk);
                in_valid = 1'b1; in_inv = (t == 1); in_tag = 4'(t); in_state = (t == 0) ? x : y;
                got = 1'b0;
                for (int k = 0; k < 10 && !got; k++) begin
                    @(negedge clk);
                    idle_inputs();
                    #1;
                    if (out_valid_m) begin
                        got = 1'b1;
                        y = out_state_m;
                    end
                end
                if (!got) begin
                    total++; bad++; $display("FAIL ident_timeout sel=%0d pair=%0d got=none want=beat", s, p);
                end
            end
            total++;
            if (y !== x) begin
                bad++; $display("FAIL ident sel=%0d pair=%0d got=%h want=%h", s, p, y, x);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        logic [255:0] x;
        sel = 0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_inv = 1'b0; in_tag = 4'(i); in_state = rnd_state(4);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (occ_m !== 3'd3) begin bad++; $display("FAIL rstm_pre_occupancy got=%0d want=3", occ_m); end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid_m !== 1'b0) begin bad++; $display("FAIL rstm_out_valid got=%b want=0", out_valid_m); end
        total++; if (occ_m !== 3'd0) begin bad++; $display("FAIL rstm_occupancy got=%0d want=0", occ_m); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        x = rnd_state(4);
        @(negedge clk);
        in_valid = 1'b1; in_inv = 1'b1; in_tag = 4'hc; in_state = x;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            total++;
            if (out_valid_m !== (k == 3)) begin
                bad++; $display("FAIL rstm_latency k=%0d got=%b want=%b", k, out_valid_m, (k == 3));
            end
        end
        total++;
        if (out_state_m !== model(x, 4, 1'b1) || out_tag_m !== 4'hc) begin
            bad++; $display("FAIL rstm_beat got=%h want=%h", out_state_m, model(x, 4, 1'b1));
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic seen;
        sel = 0; out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_inv = 1'b0; in_tag = 4'(i); in_state = rnd_state(4);
        end
        @(negedge clk);
        in_valid = 1'b1; in_tag = 4'h7; in_state = rnd_state(4); flush = 1'b1;
        #1;
        total++; if (in_ready_m !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", in_ready_m); end
        @(negedge clk);
        flush = 1'b0;
        idle_inputs();
        #1;
        total++; if (occ_m !== 3'd0) begin bad++; $display("FAIL flush_occupancy got=%0d want=0", occ_m); end
        out_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            if (out_valid_m) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_leak got=%b want=0", seen); end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_nb8_index();
        for (int s = 0; s < 3; s++) test_random(s, 300);
        test_back_to_back(1);
        test_backpressure();
        for (int s = 0; s < 3; s++) test_identity(s, 500);
        test_reset_midstream();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
